fibonacci_checker: RTL and testbench
====================================

# fibonacci_checker

Streaming consumer that verifies an incoming sequence of DATA_WIDTH-bit words is the Fibonacci series 0, 1, 1, 2, 3, 5, … computed modulo 2^DATA_WIDTH. It sits downstream of the `fibonacci` generator as a self-checking sink, in bench or on-chip BIST. It reports per-term pass pulses, a running match count and a sticky error with diagnostics. On error it back-pressures the source.

## Interface
- DATA_WIDTH, 32, width of each sequence term; all arithmetic is mod 2^DATA_WIDTH
- IDX_WIDTH, 32, width of term counter and error index
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous restart: return to expecting term 0, clear err/count
- in_valid  in  1  source presents in_data this cycle
- in_data  in  DATA_WIDTH  candidate term
- in_ready  out  1  checker accepts in_data this cycle when in_valid is also high
- term_ok  out  1  one-cycle pulse: previously accepted term matched
- err  out  1  sticky mismatch flag
- err_index  out  IDX_WIDTH  0-based index of the first mismatching term
- err_expected  out  DATA_WIDTH  expected value at the mismatch
- err_got  out  DATA_WIDTH  received value at the mismatch
- count  out  IDX_WIDTH  number of matched terms, saturates at all-ones

## Operation
- Accept = in_valid && in_ready, sampled at posedge clk.
- Expected-term window: registers a (older) and b (newer).
- States:
  - EXP0: expected 0. Accept: on match go to EXP1; on mismatch go to FAIL.
  - EXP1: expected 1. Accept: on match load a=0, b=1 and go to RUN; on mismatch go to FAIL.
  - RUN: expected = a+b, truncated to DATA_WIDTH bits with no carry kept. Accept: on match set a←b, b←expected and stay in RUN; on mismatch go to FAIL.
  - FAIL: absorbing. Only clear or rst leaves it, going to EXP0.
- in_ready = 1 in EXP0, EXP1 and RUN; in_ready = 0 in FAIL, so upstream stalls.
- Matching accept:
  - term_ok=1 next cycle.
  - count ← count+1, unless count is all-ones (it then holds).
- Mismatching accept, registered next cycle:
  - err=1.
  - err_index=count.
  - err_expected=expected value.
  - err_got=in_data.
  - term_ok=0.
- Cycles with no accept: term_ok=0; state, a, b and count hold.
- clear (synchronous, highest priority after rst):
  - state←EXP0, count←0, err←0, err_index/err_expected/err_got←0, term_ok←0, a/b←0.
  - An accept in the same cycle as clear is discarded.
- Reset values (rst low, asynchronous): state EXP0, in_ready 1, term_ok 0, err 0, err_index 0, err_expected 0, err_got 0, count 0.
- Reset mid-stream: the next accepted term is checked as index 0, so expected value is 0.

## Timing
- Latency: accept at edge N → term_ok/err/count updated at edge N+1, visible in cycle N+1.
- in_ready is a registered function of state, not combinational from in_valid.
  - in_ready falls in the cycle after the mismatching accept.
  - Exactly one term is consumed past the error, namely the bad term itself.
- Back-to-back accepts are supported at one term per cycle, with term_ok high continuously.
- in_valid gaps of any length are allowed. The window does not advance without an accept.
- Wrap-around: the sum carry is discarded. Example at DATA_WIDTH=8: term 13 = 233, term 14 = 121 (377 mod 256).
- count saturation does not affect checking.

## Structure
- Package fibonacci_pkg, shared with the generator side:
  - enum fib_chk_state_t {EXP0, EXP1, RUN, FAIL}
  - localparam FIB_SEED0 = 0, FIB_SEED1 = 1
- One natural sub-module, fib_expect:
  - holds the a/b window
  - outputs the expected term
  - advance and reset inputs
- fibonacci_checker contains the FSM, handshake, counters and error capture.

## Test plan
- Reset, then stream 0,1,1,2,3,5,8,13 back-to-back → term_ok high 8 consecutive cycles, count=8, err=0, in_ready=1 throughout.
- Stream 0,1,1,2,4 → err=1 the cycle after 4 is accepted; err_index=4, err_expected=3, err_got=4; in_ready=0; count=4; later valid terms not accepted.
- First term 1 → err_index=0, err_expected=0, err_got=1, count=0.
- DATA_WIDTH=8, stream 15 correct terms through index 14 → value 121 accepted at index 14, count=15, err=0.
- Random in_valid gaps, plus a clear pulse after term 5 that coincides with in_valid carrying 8 → that term is discarded; count=0 next cycle; a following 0,1,1 passes with count=3.
- From FAIL, assert rst low asynchronously mid-cycle → outputs reach reset values immediately; after release, 0,1 passes.

Source files
------------

// File: rtl/fibonacci_pkg.sv
// Shared Fibonacci definitions for the generator and checker sides:
// checker state encoding and sequence seeds.
package fibonacci_pkg;

    typedef enum logic [1:0] {
        EXP0 = 2'd0,
        EXP1 = 2'd1,
        RUN  = 2'd2,
        FAIL = 2'd3
    } fib_chk_state_t;

    localparam int unsigned FIB_SEED0 = 0;
    localparam int unsigned FIB_SEED1 = 1;

endpackage

// File: rtl/fibonacci_checker_if.sv
// Valid/ready stream carrying candidate Fibonacci terms from a source to the checker.
interface fibonacci_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fibonacci_checker_expect.sv
// Expected-term window: holds the two newest matched terms (a older, b newer).
// The next expected term in steady state is their wrapped sum.
module fib_expect
    import fibonacci_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_seed,
    input  logic                  i_advance,
    output logic [DATA_WIDTH-1:0] o_sum
);
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;

    // Carry out of the top bit is dropped on purpose: the series is mod 2^DATA_WIDTH.
    assign o_sum = r_a + r_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_clear) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_seed) begin
            r_a <= DATA_WIDTH'(FIB_SEED0);
            r_b <= DATA_WIDTH'(FIB_SEED1);
        end else if (i_advance) begin
            r_a <= r_b;
            r_b <= o_sum;
        end
    end
endmodule

// File: rtl/fibonacci_checker.sv
// Streaming Fibonacci sink: checks each accepted term, counts matches, and
// latches the first mismatch, stalling the source once it has failed.
module fibonacci_checker
    import fibonacci_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    fibonacci_checker_if.slave    bus,
    output logic                  o_term_ok,
    output logic                  o_err,
    output logic [IDX_WIDTH-1:0]  o_err_index,
    output logic [DATA_WIDTH-1:0] o_err_expected,
    output logic [DATA_WIDTH-1:0] o_err_got,
    output logic [IDX_WIDTH-1:0]  o_count
);
    localparam logic [1:0] S_EXP0 = EXP0;
    localparam logic [1:0] S_EXP1 = EXP1;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_FAIL = FAIL;

    logic [1:0]            r_state;
    logic                  r_ready;
    logic                  w_accept;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_expected;

    assign bus.in_ready = r_ready;
    assign w_accept     = bus.in_valid && r_ready;
    assign w_match      = (bus.in_data == w_expected);

    always_comb begin
        w_expected = w_sum;
        case (r_state)
            S_EXP0:  w_expected = DATA_WIDTH'(FIB_SEED0);
            S_EXP1:  w_expected = DATA_WIDTH'(FIB_SEED1);
            default: w_expected = w_sum;
        endcase
    end

    fib_expect #(.DATA_WIDTH(DATA_WIDTH)) u_expect (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (i_clear),
        .i_seed    (w_accept && w_match && (r_state == S_EXP1)),
        .i_advance (w_accept && w_match && (r_state == S_RUN)),
        .o_sum     (w_sum)
    );

    // in_ready is registered so the bad term is the only one consumed past an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_EXP0;
            r_ready        <= 1'b1;
            o_term_ok      <= 1'b0;
            o_err          <= 1'b0;
            o_err_index    <= '0;
            o_err_expected <= '0;
            o_err_got      <= '0;
            o_count        <= '0;
        end else if (i_clear) begin
            r_state        <= S_EXP0;
            r_ready        <= 1'b1;
            o_term_ok      <= 1'b0;
            o_err          <= 1'b0;
            o_err_index    <= '0;
            o_err_expected <= '0;
            o_err_got      <= '0;
            o_count        <= '0;
        end else begin
            o_term_ok <= 1'b0;
            if (w_accept) begin
                if (w_match) begin
                    o_term_ok <= 1'b1;
                    if (o_count != '1)
                        o_count <= o_count + 1'b1;
                    if (r_state == S_EXP0)
                        r_state <= S_EXP1;
                    else
                        r_state <= S_RUN;
                end else begin
                    r_state        <= S_FAIL;
                    r_ready        <= 1'b0;
                    o_err          <= 1'b1;
                    o_err_index    <= o_count;
                    o_err_expected <= w_expected;
                    o_err_got      <= bus.in_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_fibonacci_checker.sv
// Bench for fibonacci_checker at DATA_WIDTH=8, IDX_WIDTH=4 (exercises wrap and count saturation).
module tb_fibonacci_checker;
    localparam int DW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          term_ok;
    logic          err;
    logic [IW-1:0] err_index;
    logic [DW-1:0] err_expected;
    logic [DW-1:0] err_got;
    logic [IW-1:0] count;

    fibonacci_checker_if #(.DATA_WIDTH(DW)) bus ();

    fibonacci_checker #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (clr),
        .bus            (bus),
        .o_term_ok      (term_ok),
        .o_err          (err),
        .o_err_index    (err_index),
        .o_err_expected (err_expected),
        .o_err_got      (err_got),
        .o_count        (count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the series itself, plus "how many terms have matched so far".
    logic [DW-1:0] fib [0:255];
    int            m_idx;
    bit            m_fail;
    bit            m_ok;
    int            m_ei;
    int            m_ee;
    int            m_eg;

    function automatic int m_count();
        return (m_idx > 15) ? 15 : m_idx;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idx = 0; m_fail = 0; m_ok = 0; m_ei = 0; m_ee = 0; m_eg = 0;
    endtask

    task automatic check_model();
        chk("term_ok", int'(term_ok), int'(m_ok));
        chk("err", int'(err), int'(m_fail));
        chk("in_ready", int'(bus.in_ready), int'(!m_fail));
        chk("count", int'(count), m_count());
        chk("err_index", int'(err_index), m_ei);
        chk("err_expected", int'(err_expected), m_ee);
        chk("err_got", int'(err_got), m_eg);
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit c);
        bus.in_valid = v;
        bus.in_data  = d;
        clr          = c;
        @(posedge clk);
        #1;
        m_ok = 0;
        if (c) begin
            model_reset();
        end else if (v && !m_fail) begin
            if (d == fib[m_idx]) begin
                m_idx++;
                m_ok = 1;
            end else begin
                m_fail = 1;
                m_ei   = m_count();
                m_ee   = int'(fib[m_idx]);
                m_eg   = int'(d);
            end
        end
        bus.in_valid = 1'b0;
        clr          = 1'b0;
        check_model();
    endtask

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
        bit            c;
        bit            ok;
        bit            er;
        int            cnt;
        bit            rdy;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int k;
        bit v;
        bit c;
        logic [DW-1:0] d;

        fib[0] = 8'd0;
        fib[1] = 8'd1;
        for (int i = 2; i < 256; i++)
            fib[i] = DW'((int'(fib[i-1]) + int'(fib[i-2])) % 256);

        tbl = '{
            '{1, 8'd0,  0, 1, 0, 1, 1}, '{1, 8'd1,  0, 1, 0, 2, 1},
            '{1, 8'd1,  0, 1, 0, 3, 1}, '{1, 8'd2,  0, 1, 0, 4, 1},
            '{1, 8'd3,  0, 1, 0, 5, 1}, '{1, 8'd5,  0, 1, 0, 6, 1},
            '{1, 8'd8,  0, 1, 0, 7, 1}, '{1, 8'd13, 0, 1, 0, 8, 1},
            '{0, 8'd0,  1, 0, 0, 0, 1},
            '{1, 8'd0,  0, 1, 0, 1, 1}, '{1, 8'd1,  0, 1, 0, 2, 1},
            '{1, 8'd1,  0, 1, 0, 3, 1}, '{1, 8'd2,  0, 1, 0, 4, 1},
            '{1, 8'd4,  0, 0, 1, 4, 0},
            '{1, 8'd3,  0, 0, 1, 4, 0},
            '{1, 8'd99, 1, 0, 0, 0, 1}
        };

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        model_reset();

        // Reset values while rst is held low
        #12;
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_term_ok", int'(term_ok), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_err_index", int'(err_index), 0);
        chk("rst_err_expected", int'(err_expected), 0);
        chk("rst_err_got", int'(err_got), 0);
        rst = 1'b1;

        // Table: clean stream, clear, error stream with stall, clear discarding a term
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].c);
            chk("tbl_ok", int'(term_ok), int'(tbl[i].ok));
            chk("tbl_err", int'(err), int'(tbl[i].er));
            chk("tbl_count", int'(count), tbl[i].cnt);
            chk("tbl_ready", int'(bus.in_ready), int'(tbl[i].rdy));
            if (i == 13) begin
                chk("bad4_index", int'(err_index), 4);
                chk("bad4_expected", int'(err_expected), 3);
                chk("bad4_got", int'(err_got), 4);
            end
        end

        // First term wrong
        step(1, 8'd1, 0);
        chk("first_index", int'(err_index), 0);
        chk("first_expected", int'(err_expected), 0);
        chk("first_got", int'(err_got), 1);
        chk("first_count", int'(count), 0);

        // Wrap-around at 8 bits, then count saturation
        step(0, 8'd0, 1);
        for (int i = 0; i < 14; i++) step(1, fib[i], 0);
        step(1, 8'd121, 0);
        chk("wrap_err", int'(err), 0);
        chk("wrap_count", int'(count), 15);
        for (int i = 15; i < 25; i++) step(1, fib[i], 0);
        chk("sat_count", int'(count), 15);
        chk("sat_ok", int'(term_ok), 1);

        // Gaps, then clear coinciding with a valid 8
        step(0, 8'd0, 1);
        k = 0;
        while (k < 6) begin
            v = 1'($urandom_range(0, 1));
            step(v, fib[k], 0);
            if (v) k++;
        end
        step(1, 8'd8, 1);
        chk("clr_count", int'(count), 0);
        k = 0;
        while (k < 3) begin
            v = 1'($urandom_range(0, 1));
            step(v, fib[k], 0);
            if (v) k++;
        end
        chk("after_clr_count", int'(count), 3);
        chk("after_clr_err", int'(err), 0);

        // Randomized traffic with occasional corrupt terms and clears
        for (int n = 0; n < 800; n++) begin
            c = ($urandom_range(0, 59) == 0) || (m_idx > 200) || (m_fail && $urandom_range(0, 9) == 0);
            v = 1'($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 24) == 0) ? DW'($urandom) : fib[m_idx];
            step(v, d, c);
        end

        // Asynchronous reset out of FAIL
        step(0, 8'd0, 1);
        step(1, 8'd5, 0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("arst_in_ready", int'(bus.in_ready), 1);
        chk("arst_err", int'(err), 0);
        chk("arst_term_ok", int'(term_ok), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_err_index", int'(err_index), 0);
        chk("arst_err_expected", int'(err_expected), 0);
        chk("arst_err_got", int'(err_got), 0);
        #2 rst = 1'b1;
        step(1, 8'd0, 0);
        step(1, 8'd1, 0);
        chk("arst_resume_count", int'(count), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
